key_entry_manager: RTL and testbench

Keypad front end feeding the door-lock `StateManager`. It turns debounced keypad strobes into the `is_on`, `is_star_pressed` and `correct` signals that `StateManager` consumes. It also holds the digit entry buffer and the stored password, and commits a new password when a reset sequence completes. It reads back the 3-bit lock state so that key acceptance and password commit match the lock's current mode.

---
 rtl/key_entry_if.sv | 25 ++
 rtl/key_entry_manager.sv | 161 ++++++++++++++++
 tb/tb_key_entry_manager.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/key_entry_if.sv
// Keypad/StateManager bundle for key_entry_manager.
// master drives keys and lock state; slave is the entry manager.
interface key_entry_if #(
  parameter int unsigned MAX_DIGITS = 8
);
  logic                    key_valid;
  logic [3:0]              key_code;
  logic [2:0]              state;
  logic                    is_on;
  logic                    is_star_pressed;
  logic                    correct;
  logic [3:0]              digit_count;
  logic [4*MAX_DIGITS-1:0] entry;
  logic                    pw_updated;

  modport master (
    output key_valid, key_code, state,
    input  is_on, is_star_pressed, correct, digit_count, entry, pw_updated
  );

  modport slave (
    input  key_valid, key_code, state,
    output is_on, is_star_pressed, correct, digit_count, entry, pw_updated
  );
endinterface

// File: rtl/key_entry_manager.sv
// Keypad front end: digit buffer, stored password and is_on/star/correct for StateManager.
// Optional macro KEY_ENTRY_MASK_EN displays occupied nibbles of entry as 4'hF.
module key_entry_manager #(
  parameter int unsigned MAX_DIGITS  = 8,
  parameter int unsigned MIN_DIGITS  = 4,
  parameter logic [31:0] DEFAULT_PW  = 32'h0000_1234,
  parameter int unsigned DEFAULT_LEN = 4,
  parameter int unsigned HOLD_CYCLES = 100000
) (
  input logic        clk,
  input logic        initialize,
  key_entry_if.slave bus
);
  localparam int unsigned ENT_W   = 4 * MAX_DIGITS;
  localparam int unsigned TMR_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0]  MAX_CNT = 4'(MAX_DIGITS);
  localparam logic [3:0]  MIN_CNT = 4'(MIN_DIGITS);
  localparam logic [3:0]  KEY_STAR = 4'hA;
  localparam logic [3:0]  KEY_HASH = 4'hB;
  localparam logic [3:0]  KEY_CLR  = 4'hC;
  localparam logic [2:0]  ST_OFF   = 3'b000;
  localparam logic [2:0]  ST_ON    = 3'b001;
  localparam logic [2:0]  ST_W1    = 3'b010;
  localparam logic [2:0]  ST_W2    = 3'b011;
  localparam logic [2:0]  ST_RESET = 3'b101;
  localparam logic [2:0]  ST_LOCK  = 3'b111;

  typedef enum logic {ENTRY, HOLD} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [ENT_W-1:0] buf_q, buf_d, pw_q, pw_d, disp_q, disp_d;
  logic [3:0]       cnt_q, cnt_d, pwlen_q, pwlen_d;
  logic [2:0]       hold_q, hold_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             on_q, on_d, star_q, star_d, corr_q, corr_d, pwu_q, pwu_d;
  logic             locked, digit_ok, is_digit, hold_exit;

  // Length match plus low-nibble compare, qualified by the lock mode.
  function automatic logic eval_correct(input logic [2:0] st, input logic [ENT_W-1:0] b,
                                        input logic [3:0] n, input logic [ENT_W-1:0] p,
                                        input logic [3:0] pn);
    logic m;
    m = (n == pn);
    for (int i = 0; i < int'(MAX_DIGITS); i++)
      if (i < int'(n) && b[4*i +: 4] != p[4*i +: 4]) m = 1'b0;
    case (st)
      ST_ON, ST_W1, ST_W2: return m;
      ST_RESET:            return n >= MIN_CNT;
      default:             return 1'b0;
    endcase
  endfunction

`ifdef KEY_ENTRY_MASK_EN
  function automatic logic [ENT_W-1:0] mask_of(input logic [3:0] n);
    logic [ENT_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MAX_DIGITS); i++)
      if (i < int'(n)) m[4*i +: 4] = 4'hF;
    return m;
  endfunction
  assign disp_d = mask_of(cnt_d);
`else
  assign disp_d = buf_d;
`endif

  always_ff @(posedge clk) begin
    if (initialize) begin
      fsm_q   <= ENTRY;
      buf_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      pw_q    <= ENT_W'(DEFAULT_PW);
      pwlen_q <= 4'(DEFAULT_LEN);
      hold_q  <= '0;
      tmr_q   <= '0;
      on_q    <= 1'b0;
      star_q  <= 1'b0;
      corr_q  <= 1'b0;
      pwu_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      buf_q   <= buf_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      pwlen_q <= pwlen_d;
      hold_q  <= hold_d;
      tmr_q   <= tmr_d;
      on_q    <= on_d;
      star_q  <= star_d;
      corr_q  <= corr_d;
      pwu_q   <= pwu_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    pw_d      = pw_q;
    pwlen_d   = pwlen_q;
    hold_d    = hold_q;
    tmr_d     = tmr_q;
    on_d      = on_q;
    star_d    = 1'b0;
    pwu_d     = 1'b0;
    corr_d    = corr_q;
    locked    = (bus.state == ST_LOCK);
    digit_ok  = bus.state inside {ST_ON, ST_W1, ST_W2, ST_RESET};
    is_digit  = (bus.key_code <= 4'd9);
    hold_exit = (bus.state != hold_q) || (tmr_q == '0);
    case (fsm_q)
      ENTRY: begin
        if (bus.key_valid && !locked) begin
          if (is_digit) begin
            if (digit_ok && cnt_q < MAX_CNT) begin
              buf_d = (buf_q << 4) | ENT_W'(bus.key_code);
              cnt_d = cnt_q + 4'd1;
            end
          end else if (bus.key_code == KEY_CLR) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (bus.key_code == KEY_HASH) begin
            on_d = !on_q;
          end else if (bus.key_code == KEY_STAR) begin
            star_d = 1'b1;
            hold_d = bus.state;
            tmr_d  = TMR_W'(HOLD_CYCLES - 1);
            fsm_d  = HOLD;
          end
        end
        corr_d = eval_correct(bus.state, buf_d, cnt_d, pw_q, pwlen_q);
      end
      HOLD: begin
        tmr_d = tmr_q - TMR_W'(1);
        // Keys landing on the exit cycle are dropped, including '#'.
        if (hold_exit) begin
          fsm_d = ENTRY;
          buf_d = '0;
          cnt_d = '0;
          if (hold_q == ST_RESET && bus.state == ST_OFF && cnt_q >= MIN_CNT) begin
            pw_d    = buf_q;
            pwlen_d = cnt_q;
            pwu_d   = 1'b1;
          end
          corr_d = eval_correct(bus.state, '0, '0, pw_q, pwlen_q);
        end else if (bus.key_valid && bus.key_code == KEY_HASH && !locked) begin
          on_d = !on_q;
        end
      end
      default: fsm_d = ENTRY;
    endcase
  end

  assign bus.is_on           = on_q;
  assign bus.is_star_pressed = star_q;
  assign bus.correct         = corr_q;
  assign bus.digit_count     = cnt_q;
  assign bus.entry           = disp_q;
  assign bus.pw_updated      = pwu_q;
endmodule

// File: tb/tb_key_entry_manager.sv
// Bench for key_entry_manager: directed scenarios plus random keys/states vs a queue-based model.
module tb_key_entry_manager;
  localparam int HOLD = 20;
  localparam int MAXD = 8;
  localparam int MIND = 4;

  logic clk = 1'b0;
  logic initialize;
  int   checks = 0;
  int   failures = 0;

  key_entry_if #(.MAX_DIGITS(MAXD)) bus ();

  key_entry_manager #(
    .MAX_DIGITS (MAXD),
    .MIN_DIGITS (MIND),
    .DEFAULT_PW (32'h0000_1234),
    .DEFAULT_LEN(4),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .initialize(initialize),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: digits oldest-first, password as a digit list.
  logic [3:0] dq[$];
  logic [3:0] pwq[$];
  bit         m_on, m_corr, m_star, m_pwu, in_hold;
  logic [2:0] hs;
  int         elapsed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_correct(input logic [2:0] st);
    if (st == 3'd5) return dq.size() >= MIND;
    if (!(st inside {3'd1, 3'd2, 3'd3})) return 1'b0;
    if (dq.size() != pwq.size()) return 1'b0;
    foreach (dq[i]) if (dq[i] != pwq[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_entry();
    logic [31:0] e;
    e = '0;
    foreach (dq[i]) begin
`ifdef KEY_ENTRY_MASK_EN
      e = {e[27:0], 4'hF};
`else
      e = {e[27:0], dq[i]};
`endif
    end
    return e;
  endfunction

  task automatic model_step(input bit ini, input bit kv, input logic [3:0] kc, input logic [2:0] st);
    m_star = 1'b0;
    m_pwu  = 1'b0;
    if (ini) begin
      dq.delete();
      pwq = '{4'd1, 4'd2, 4'd3, 4'd4};
      m_on = 1'b0; m_corr = 1'b0; in_hold = 1'b0; elapsed = 0;
    end else if (!in_hold) begin
      if (kv && st != 3'd7) begin
        if (kc <= 4'd9) begin
          if (st inside {3'd1, 3'd2, 3'd3, 3'd5} && dq.size() < MAXD) dq.push_back(kc);
        end else if (kc == 4'hC) dq.delete();
        else if (kc == 4'hB) m_on = !m_on;
        else if (kc == 4'hA) begin
          m_star = 1'b1; in_hold = 1'b1; hs = st; elapsed = 0;
        end
      end
      m_corr = model_correct(st);
    end else begin
      elapsed++;
      if (st != hs || elapsed == HOLD) begin
        in_hold = 1'b0;
        if (hs == 3'd5 && st == 3'd0 && dq.size() >= MIND) begin
          pwq = dq;
          m_pwu = 1'b1;
        end
        dq.delete();
        m_corr = model_correct(st);
      end else if (kv && kc == 4'hB && st != 3'd7) begin
        m_on = !m_on;
      end
    end
  endtask

  task automatic step(input bit ini, input bit kv, input logic [3:0] kc, input logic [2:0] st);
    initialize    = ini;
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.state     = st;
    @(posedge clk);
    model_step(ini, kv, kc, st);
    #1;
    check("is_on",       32'(bus.is_on),           32'(m_on));
    check("star",        32'(bus.is_star_pressed), 32'(m_star));
    check("correct",     32'(bus.correct),         32'(m_corr));
    check("digit_count", 32'(bus.digit_count),     32'(dq.size()));
    check("entry",       bus.entry,                model_entry());
    check("pw_updated",  32'(bus.pw_updated),      32'(m_pwu));
  endtask

  task automatic key(input logic [3:0] kc, input logic [2:0] st);
    step(1'b0, 1'b1, kc, st);
  endtask

  task automatic idle(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, st);
  endtask

  logic [2:0] st_tab[7];
  logic [2:0] rst_state;

  initial begin
    st_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    step(1'b1, 1'b0, 4'h0, 3'd0);
    check("rst_entry", bus.entry, 32'h0);
    check("rst_on", 32'(bus.is_on), 32'd0);

    // Correct password, star, StateManager opens.
    idle(3'd1, 1);
    for (int d = 1; d <= 4; d++) key(4'(d), 3'd1);
    check("tp1_entry", bus.entry, 32'h0000_1234);
    check("tp1_correct", 32'(bus.correct), 32'd1);
    key(4'hA, 3'd1);
    check("tp1_star", 32'(bus.is_star_pressed), 32'd1);
    idle(3'd1, 3);
    key(4'hB, 3'd1);
    check("tp1_hold_correct", 32'(bus.correct), 32'd1);
    idle(3'd4, 1);
    check("tp1_cleared", 32'(bus.digit_count), 32'd0);

    // Wrong password.
    idle(3'd1, 1);
    key(4'd1, 3'd1); key(4'd2, 3'd1); key(4'd3, 3'd1); key(4'd5, 3'd1); key(4'hA, 3'd1);
    check("tp2_correct", 32'(bus.correct), 32'd0);
    idle(3'd2, 1);
    check("tp2_cleared", 32'(bus.digit_count), 32'd0);

    // Too-short new password is not committed.
    idle(3'd5, 1);
    key(4'd1, 3'd5); key(4'd2, 3'd5); key(4'd3, 3'd5); key(4'hA, 3'd5);
    check("tp4_correct", 32'(bus.correct), 32'd0);
    idle(3'd0, 1);
    check("tp4_no_pwu", 32'(bus.pw_updated), 32'd0);
    idle(3'd1, 1);
    for (int d = 1; d <= 4; d++) key(4'(d), 3'd1);
    check("tp4_old_pw", 32'(bus.correct), 32'd1);
    key(4'hC, 3'd1);

    // Five-digit password commit.
    idle(3'd5, 1);
    for (int d = 9; d >= 5; d--) key(4'(d), 3'd5);
    key(4'hA, 3'd5);
    idle(3'd0, 1);
    check("tp3_pwu", 32'(bus.pw_updated), 32'd1);
    idle(3'd1, 1);
    for (int d = 9; d >= 5; d--) key(4'(d), 3'd1);
    check("tp3_new_pw", 32'(bus.correct), 32'd1);
    key(4'hC, 3'd1);
    for (int d = 1; d <= 4; d++) key(4'(d), 3'd1);
    check("tp3_old_rejected", 32'(bus.correct), 32'd0);
    key(4'hC, 3'd1);

    // Full buffer and exact timeout.
    for (int d = 1; d <= 9; d++) key(4'(d), 3'd1);
    check("tp5_count", 32'(bus.digit_count), 32'd8);
    check("tp5_entry", bus.entry, 32'h1234_5678);
    key(4'hA, 3'd1);
    idle(3'd1, HOLD - 1);
    check("tp5_still_hold", 32'(bus.digit_count), 32'd8);
    idle(3'd1, 1);
    check("tp5_timeout", 32'(bus.digit_count), 32'd0);

    // Lock ignores keys; initialize mid-hold.
    idle(3'd7, 1);
    key(4'd3, 3'd7); key(4'hA, 3'd7); key(4'hB, 3'd7);
    check("tp6_lock_count", 32'(bus.digit_count), 32'd0);
    key(4'hB, 3'd1);
    key(4'd7, 3'd1); key(4'hA, 3'd1);
    idle(3'd1, 2);
    step(1'b1, 1'b1, 4'hB, 3'd1);
    check("tp6_init_on", 32'(bus.is_on), 32'd0);
    check("tp6_init_count", 32'(bus.digit_count), 32'd0);

    // Random keys and lock-state changes.
    rst_state = 3'd1;
    for (int c = 0; c < 4000; c++) begin
      bit         ini, kv;
      logic [3:0] kc;
      ini = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) rst_state = st_tab[$urandom_range(0, 6)];
      kv = ($urandom_range(0, 1) == 1);
      kc = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      step(ini, kv, kc, rst_state);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
